// File: rtl/als_param_if.sv
// Handshake and operand/result bundle for the als_param ALU/shift unit.
// The control side drives start and operands; the unit returns busy/done, result and status flags.
interface als_param_if #(parameter int WIDTH = 32);
   localparam int SHW = $clog2(WIDTH);

   logic             start;
   logic             operation;
   logic [2:0]       alu_sel;
   logic [2:0]       funct;
   logic [WIDTH-1:0] oper_a;
   logic [WIDTH-1:0] oper_b;
   logic [SHW-1:0]   shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             negative;
   logic             zero;
   logic             equal;
   logic             greater;
   logic             lesser;

   modport master (
      output start, operation, alu_sel, funct, oper_a, oper_b, shamt,
      input  busy, done, result, overflow, negative, zero, equal, greater, lesser
   );

   modport slave (
      input  start, operation, alu_sel, funct, oper_a, oper_b, shamt,
      output busy, done, result, overflow, negative, zero, equal, greater, lesser
   );
endinterface

// File: rtl/als_param.sv
// Execute-stage ALU plus iterative shifter/rotator sharing one start/busy/done handshake.
// ALU ops complete in one cycle; shifts move up to STEP bit positions per cycle.
module als_param #(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 1,
   localparam int SHW   = $clog2(WIDTH)
) (
   input logic        Clk,
   input logic        reset,
   als_param_if.slave bus
);

   typedef enum logic {IDLE, SHIFT} stateT;

   localparam logic [SHW:0] STEPW = (SHW + 1)'(STEP);

   stateT            state, nextState;
   logic [WIDTH-1:0] shreg, nextShreg;
   logic [SHW-1:0]   count, nextCount;
   logic [2:0]       fn, nextFn;
   logic [WIDTH-1:0] res, nextRes;
   logic [5:0]       flags, nextFlags;
   logic             doneReg, nextDone;

   logic [WIDTH-1:0]   aluRes;
   logic               aluOvf;
   logic               cmpEq, cmpGt, cmpLt;
   logic [SHW-1:0]     k;
   logic [WIDTH-1:0]   stepped;
   logic [2*WIDTH-1:0] dbl, rorW, rolW;

   // Flag vector layout: {overflow, negative, zero, equal, greater, lesser}
   function automatic logic [5:0] shiftFlags(input logic [WIDTH-1:0] r);
      return {1'b0, r[WIDTH-1], (r == '0), 3'b000};
   endfunction

   // Hold and the two reserved codes pass oper_a through without iterating
   function automatic logic isHold(input logic [2:0] f);
      return (f == 3'b000) || (f[2:1] == 2'b11);
   endfunction

   always_comb begin
      aluRes = bus.oper_a;
      aluOvf = 1'b0;
      case (bus.alu_sel)
         3'b000: aluRes = bus.oper_a;
         3'b001: begin
            aluRes = bus.oper_a + bus.oper_b;
            aluOvf = (bus.oper_a[WIDTH-1] == bus.oper_b[WIDTH-1]) &&
                     (aluRes[WIDTH-1] != bus.oper_a[WIDTH-1]);
         end
         3'b010: begin
            aluRes = bus.oper_a - bus.oper_b;
            aluOvf = (bus.oper_a[WIDTH-1] != bus.oper_b[WIDTH-1]) &&
                     (aluRes[WIDTH-1] != bus.oper_a[WIDTH-1]);
         end
         3'b011: aluRes = bus.oper_a & bus.oper_b;
         3'b100: begin
            aluRes = bus.oper_a + WIDTH'(1);
            aluOvf = ~bus.oper_a[WIDTH-1] & aluRes[WIDTH-1];
         end
         3'b101: aluRes = ~bus.oper_a;
         3'b110: aluRes = bus.oper_a ^ bus.oper_b;
         3'b111: aluRes = bus.oper_a | bus.oper_b;
      endcase
      cmpEq = (bus.oper_a == bus.oper_b);
      cmpGt = ($signed(bus.oper_a) > $signed(bus.oper_b));
      cmpLt = !cmpEq && !cmpGt;
   end

   // One shifter iteration; rotates use a doubled copy so the wrap falls out naturally
   always_comb begin
      k       = ({1'b0, count} < STEPW) ? count : STEPW[SHW-1:0];
      dbl     = {shreg, shreg};
      rorW    = dbl >> k;
      rolW    = dbl << k;
      stepped = shreg;
      case (fn)
         3'b001:  stepped = shreg << k;
         3'b010:  stepped = shreg >> k;
         3'b011:  stepped = $signed(shreg) >>> k;
         3'b100:  stepped = rorW[WIDTH-1:0];
         3'b101:  stepped = rolW[2*WIDTH-1:WIDTH];
         default: stepped = shreg;
      endcase
   end

   always_comb begin
      nextState = state;
      nextShreg = shreg;
      nextCount = count;
      nextFn    = fn;
      nextRes   = res;
      nextFlags = flags;
      nextDone  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (!bus.operation) begin
                  nextRes   = aluRes;
                  nextFlags = {aluOvf, aluRes[WIDTH-1], (aluRes == '0), cmpEq, cmpGt, cmpLt};
                  nextDone  = 1'b1;
               end else begin
                  nextShreg = bus.oper_a;
                  nextCount = bus.shamt;
                  nextFn    = bus.funct;
                  if ((bus.shamt == '0) || isHold(bus.funct)) begin
                     nextCount = '0;
                     nextRes   = bus.oper_a;
                     nextFlags = shiftFlags(bus.oper_a);
                     nextDone  = 1'b1;
                  end else begin
                     nextState = SHIFT;
                  end
               end
            end
         end
         SHIFT: begin
            nextShreg = stepped;
            nextCount = count - k;
            if (count == k) begin
               nextRes   = stepped;
               nextFlags = shiftFlags(stepped);
               nextDone  = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!reset) begin
         state   <= IDLE;
         shreg   <= '0;
         count   <= '0;
         fn      <= '0;
         res     <= '0;
         flags   <= '0;
         doneReg <= 1'b0;
      end else begin
         state   <= nextState;
         shreg   <= nextShreg;
         count   <= nextCount;
         fn      <= nextFn;
         res     <= nextRes;
         flags   <= nextFlags;
         doneReg <= nextDone;
      end
   end

   assign bus.busy     = (state == SHIFT);
   assign bus.done     = doneReg;
   assign bus.result   = res;
   assign bus.overflow = flags[5];
   assign bus.negative = flags[4];
   assign bus.zero     = flags[3];
   assign bus.equal    = flags[2];
   assign bus.greater  = flags[1];
   assign bus.lesser   = flags[0];

endmodule

// File: tb/tb_als_param.sv
// Bench for als_param: table of ALU/shift vectors through a scoreboard queue, plus hand-built
// sequences for ignored start, back-to-back issue, mid-shift reset and a 16-bit instance.
module tb_als_param;

   typedef struct {
      int          sel;
      logic        op;
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] expRes;
      logic [5:0]  expFlags;
      int          lat;
   } vecT;

   logic Clk;
   logic reset;
   int   checks;
   int   errors;

   int          sel;
   logic        tStart, tOp;
   logic [2:0]  tAlu, tFunct;
   logic [31:0] tA, tB;
   logic [4:0]  tSh;

   logic        s16Start, s16Op;
   logic [2:0]  s16Alu, s16Funct;
   logic [15:0] s16A, s16B;
   logic [3:0]  s16Sh;

   logic        obsDone, obsBusy;
   logic [31:0] obsRes;
   logic [5:0]  obsFlags;

   vecT expQ[$];
   vecT vecs[20];

   als_param_if #(.WIDTH(32)) if1 ();
   als_param_if #(.WIDTH(32)) if4 ();
   als_param_if #(.WIDTH(16)) if16 ();

   als_param #(.WIDTH(32), .STEP(1)) dut1  (.Clk(Clk), .reset(reset), .bus(if1));
   als_param #(.WIDTH(32), .STEP(4)) dut4  (.Clk(Clk), .reset(reset), .bus(if4));
   als_param #(.WIDTH(16), .STEP(1)) dut16 (.Clk(Clk), .reset(reset), .bus(if16));

   assign if1.start     = tStart && (sel == 0);
   assign if1.operation = tOp;
   assign if1.alu_sel   = tAlu;
   assign if1.funct     = tFunct;
   assign if1.oper_a    = tA;
   assign if1.oper_b    = tB;
   assign if1.shamt     = tSh;

   assign if4.start     = tStart && (sel == 1);
   assign if4.operation = tOp;
   assign if4.alu_sel   = tAlu;
   assign if4.funct     = tFunct;
   assign if4.oper_a    = tA;
   assign if4.oper_b    = tB;
   assign if4.shamt     = tSh;

   assign if16.start     = s16Start;
   assign if16.operation = s16Op;
   assign if16.alu_sel   = s16Alu;
   assign if16.funct     = s16Funct;
   assign if16.oper_a    = s16A;
   assign if16.oper_b    = s16B;
   assign if16.shamt     = s16Sh;

   always_comb begin
      if (sel == 1) begin
         obsDone  = if4.done;
         obsBusy  = if4.busy;
         obsRes   = if4.result;
         obsFlags = {if4.overflow, if4.negative, if4.zero, if4.equal, if4.greater, if4.lesser};
      end else begin
         obsDone  = if1.done;
         obsBusy  = if1.busy;
         obsRes   = if1.result;
         obsFlags = {if1.overflow, if1.negative, if1.zero, if1.equal, if1.greater, if1.lesser};
      end
   end

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vecT v, input bit push);
      @(posedge Clk); #1;
      sel    = v.sel;
      tOp    = v.op;
      tAlu   = v.code;
      tFunct = v.code;
      tA     = v.a;
      tB     = v.b;
      tSh    = v.sh;
      tStart = 1'b1;
      if (push) expQ.push_back(v);
      @(posedge Clk); #1;
      tStart = 1'b0;
   endtask

   task automatic compareFront(input int lat);
      vecT e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard empty at done");
         return;
      end
      e = expQ.pop_front();
      checkVal("done", 32'(obsDone), 32'd1);
      checkVal("latency", 32'(lat), 32'(e.lat));
      checkVal("result", obsRes, e.expRes);
      checkVal("flags", 32'(obsFlags), 32'(e.expFlags));
      checkVal("busyAtDone", 32'(obsBusy), 32'd0);
   endtask

   task automatic checkOutput(input int firstCyc);
      int  cyc;
      bit  seen;
      int  expLat;
      seen   = 1'b0;
      expLat = (expQ.size() > 0) ? expQ[0].lat : 1;
      for (cyc = firstCyc; cyc <= 40; cyc++) begin
         @(negedge Clk);
         if (cyc == 1) checkVal("busyCycle1", 32'(obsBusy), (expLat > 1) ? 32'd1 : 32'd0);
         if (obsDone) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done timeout actual=none required=cycle %0d", expLat);
         if (expQ.size() > 0) void'(expQ.pop_front());
      end else begin
         compareFront(cyc);
      end
   endtask

   initial begin
      vecT v;
      vecT v2;
      int  extra;

      checks = 0;
      errors = 0;
      reset  = 1'b0;
      sel = 0; tStart = 0; tOp = 0; tAlu = 0; tFunct = 0; tA = 0; tB = 0; tSh = 0;
      s16Start = 0; s16Op = 0; s16Alu = 0; s16Funct = 0; s16A = 0; s16B = 0; s16Sh = 0;

      // {sel, op, code, a, b, shamt, result, {ovf,neg,zero,eq,gt,lt}, done cycle}
      vecs[0]  = '{0, 1'b0, 3'b001, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 6'b110010, 1};
      vecs[1]  = '{0, 1'b0, 3'b010, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 6'b001100, 1};
      vecs[2]  = '{0, 1'b0, 3'b010, 32'hFFFFFFFD, 32'h00000002, 5'd0,  32'hFFFFFFFB, 6'b010001, 1};
      vecs[3]  = '{0, 1'b0, 3'b000, 32'h00001234, 32'h00001234, 5'd0,  32'h00001234, 6'b000100, 1};
      vecs[4]  = '{0, 1'b0, 3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 6'b000001, 1};
      vecs[5]  = '{1, 1'b0, 3'b100, 32'h7FFFFFFF, 32'h00000000, 5'd0,  32'h80000000, 6'b110010, 1};
      vecs[6]  = '{0, 1'b0, 3'b101, 32'hFFFFFFFF, 32'h00000000, 5'd0,  32'h00000000, 6'b001001, 1};
      vecs[7]  = '{0, 1'b0, 3'b110, 32'hAAAA5555, 32'hFFFF0000, 5'd0,  32'h55555555, 6'b000001, 1};
      vecs[8]  = '{0, 1'b0, 3'b111, 32'h80000000, 32'h00000001, 5'd0,  32'h80000001, 6'b010001, 1};
      vecs[9]  = '{0, 1'b0, 3'b010, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 6'b100001, 1};
      vecs[10] = '{0, 1'b1, 3'b011, 32'h80000000, 32'h00000000, 5'd4,  32'hF8000000, 6'b010000, 5};
      vecs[11] = '{0, 1'b1, 3'b001, 32'h00000003, 32'h00000000, 5'd3,  32'h00000018, 6'b000000, 4};
      vecs[12] = '{1, 1'b1, 3'b010, 32'h80000000, 32'h00000000, 5'd31, 32'h00000001, 6'b000000, 9};
      vecs[13] = '{1, 1'b1, 3'b100, 32'h00000001, 32'h00000000, 5'd5,  32'h08000000, 6'b000000, 3};
      vecs[14] = '{0, 1'b1, 3'b101, 32'h80000001, 32'h00000000, 5'd1,  32'h00000003, 6'b000000, 2};
      vecs[15] = '{1, 1'b1, 3'b001, 32'hFFFFFFFF, 32'h00000000, 5'd0,  32'hFFFFFFFF, 6'b010000, 1};
      vecs[16] = '{0, 1'b1, 3'b111, 32'h000000A5, 32'h00000000, 5'd7,  32'h000000A5, 6'b000000, 1};
      vecs[17] = '{0, 1'b1, 3'b000, 32'h00000000, 32'h00000000, 5'd9,  32'h00000000, 6'b001000, 1};
      vecs[18] = '{1, 1'b1, 3'b011, 32'h80000000, 32'h00000000, 5'd31, 32'hFFFFFFFF, 6'b010000, 9};
      vecs[19] = '{1, 1'b1, 3'b001, 32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 6'b010000, 9};

      repeat (3) @(posedge Clk);
      #1 reset = 1'b1;
      @(negedge Clk);
      checkVal("rst1 result", if1.result, 32'h0);
      checkVal("rst1 ctrl", {29'b0, if1.busy, if1.done, if1.overflow | if1.negative | if1.zero |
               if1.equal | if1.greater | if1.lesser}, 32'h0);
      checkVal("rst4 result", if4.result, 32'h0);
      checkVal("rst4 ctrl", {30'b0, if4.busy, if4.done}, 32'h0);
      checkVal("rst16 result", {16'b0, if16.result}, 32'h0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i], 1'b1);
         checkOutput(1);
      end

      // A start raised while busy must be ignored, operands included
      v = '{0, 1'b1, 3'b011, 32'h80000000, 32'h00000000, 5'd4, 32'hF8000000, 6'b010000, 5};
      applyStimulus(v, 1'b1);
      @(negedge Clk);
      checkVal("ignored busyC1", 32'(obsBusy), 32'd1);
      @(posedge Clk); #1;
      tStart = 1'b1; tOp = 1'b0; tAlu = 3'b001; tFunct = 3'b001; tA = 32'h1; tB = 32'h1; tSh = 5'd1;
      @(negedge Clk);
      checkVal("ignored busyC2", 32'(obsBusy), 32'd1);
      @(posedge Clk); #1;
      tStart = 1'b0;
      checkOutput(3);
      extra = 0;
      repeat (6) begin
         @(negedge Clk);
         if (obsDone) extra++;
      end
      checkVal("ignored noSecondDone", 32'(extra), 32'd0);

      // Back-to-back issue: new start in the done cycle of a long rotate
      v  = '{1, 1'b1, 3'b101, 32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 6'b010000, 9};
      v2 = '{1, 1'b1, 3'b001, 32'h00001234, 32'h00000000, 5'd0,  32'h00001234, 6'b000000, 1};
      applyStimulus(v, 1'b1);
      repeat (8) begin
         @(posedge Clk); #1;
      end
      tStart = 1'b1; tOp = 1'b1; tFunct = 3'b001; tAlu = 3'b001; tA = 32'h1234; tSh = 5'd0;
      expQ.push_back(v2);
      @(negedge Clk);
      compareFront(9);
      @(posedge Clk); #1;
      tStart = 1'b0;
      @(negedge Clk);
      compareFront(1);

      // Reset in the middle of a long shift clears everything and suppresses done
      applyStimulus(vecs[0], 1'b1);
      checkOutput(1);
      v = '{0, 1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000000, 5'd20, 32'h00000FFF, 6'b000000, 21};
      applyStimulus(v, 1'b0);
      repeat (4) begin
         @(posedge Clk); #1;
      end
      reset = 1'b0;
      @(posedge Clk); #1;
      reset = 1'b1;
      @(negedge Clk);
      checkVal("midReset busy", 32'(obsBusy), 32'd0);
      checkVal("midReset done", 32'(obsDone), 32'd0);
      checkVal("midReset result", obsRes, 32'h0);
      checkVal("midReset flags", 32'(obsFlags), 32'h0);
      extra = 0;
      repeat (30) begin
         @(negedge Clk);
         if (obsDone) extra++;
      end
      checkVal("midReset noDone", 32'(extra), 32'd0);

      // 16-bit instance: increment wraps to zero without signed overflow
      @(posedge Clk); #1;
      s16Start = 1'b1; s16Op = 1'b0; s16Alu = 3'b100; s16A = 16'hFFFF; s16B = 16'h0000;
      @(posedge Clk); #1;
      s16Start = 1'b0;
      @(negedge Clk);
      checkVal("w16 done", 32'(if16.done), 32'd1);
      checkVal("w16 result", {16'b0, if16.result}, 32'h0);
      checkVal("w16 flags", {26'b0, if16.overflow, if16.negative, if16.zero, if16.equal,
               if16.greater, if16.lesser}, 32'b001001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/als_param.md
Name: als_param

Overview:
- Next-generation ALU/shift unit for the MIPS datapath, parametrised in data width and shift throughput.
- A single start/busy/done handshake serves both paths, selected by `operation`.
  - ALU path: one-cycle registered result with compare flags.
  - Shift path: multi-cycle iterative shifter that moves STEP bit positions per cycle. It adds rotates, and operands are captured only on `start`.
- Sits in the execute stage. The control FSM issues `start` and stalls on `busy`.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, power of two).
- STEP, 1, bit positions shifted per cycle (1..WIDTH).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch an operation; sampled only when not busy.
- operation  in  1  0=ALU, 1=shift.
- alu_sel  in  3  ALU opcode.
- funct  in  3  shift opcode.
- oper_a  in  WIDTH  ALU operand A / value to shift.
- oper_b  in  WIDTH  ALU operand B.
- shamt  in  SHW  shift amount.
- busy  out  1  shift in progress; start ignored.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  last completed result; held until the next completion.
- overflow, negative, zero, equal, greater, lesser  out  1 each  status flags; held with `result`.

Behaviour:
- Clock and reset:
  - One clock, Clk.
  - reset is synchronous and active-low: reset==0 at a rising edge clears all state.
- Reset values:
  - result=0, all flags=0, done=0, busy=0, state=IDLE, internal count=0.
  - Reset asserted mid-shift aborts the operation; no done pulse is produced.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 in cycle 0, operation=0 (ALU):
  - result and flags are registered at the edge ending cycle 0.
  - done=1 in cycle 1; state stays IDLE.
- IDLE, start=1 in cycle 0, operation=1 (shift):
  - Shift register loads oper_a; count loads shamt; funct is captured.
  - If shamt==0: done=1 in cycle 1 with result=oper_a; state stays IDLE.
  - Otherwise state goes to SHIFT with busy=1.
- SHIFT:
  - Each cycle, shift by k=min(STEP,count) and set count-=k.
  - When count reaches 0, result updates and state returns to IDLE.
  - done=1 in cycle 1+ceil(shamt/STEP). busy=1 in cycles 1..ceil(shamt/STEP); busy=0 in the done cycle.
- start handling:
  - start while busy is ignored, and its operands are not captured.
  - start in a done cycle is accepted (back-to-back issue).
- ALU ops:
  - 000 A, 001 A+B, 010 A-B, 011 A&B, 100 A+1, 101 ~A, 110 A^B, 111 A|B.
  - All arithmetic is modulo 2^WIDTH.
- ALU flags:
  - overflow: signed overflow on 001/010/100; 0 otherwise.
  - negative: result[WIDTH-1].
  - zero: result==0.
  - equal/greater/lesser: signed comparison of A against B, updated on every ALU op. Exactly one of the three is 1.
- Shift ops:
  - 000 hold (result=oper_a, count ignored), 001 SLL, 010 SRL, 011 SRA (sign fill), 100 ROR, 101 ROL.
  - 110 and 111 are reserved and behave as 000.
- Shift flags:
  - negative and zero are computed from result.
  - overflow, equal, greater, lesser are forced to 0.
- Width rules:
  - shamt max is WIDTH-1.
  - Rotates wrap modulo WIDTH.
  - SRA of a negative value saturates toward all-ones.

Test Plan:
1. WIDTH=32: start, op=0, alu_sel=001, A=0x7FFFFFFF, B=1 -> cycle 1: done=1, result=0x80000000, overflow=1, negative=1, zero=0, greater=1.
2. alu_sel=010, A=B=5 -> cycle 1: result=0, zero=1, equal=1, overflow=0. Then A=-3, B=2 -> result=0xFFFFFFFB, lesser=1, negative=1.
3. STEP=1: op=1, funct=011 SRA, A=0x80000000, shamt=4 -> busy=1 in cycles 1-4; done=1 in cycle 5 with result=0xF8000000, negative=1. A second start asserted in cycle 2 is ignored.
4. STEP=4: funct=101 ROL, A=0x00000001, shamt=31 -> done in cycle 9, result=0x80000000. Back-to-back start in cycle 9 with SLL shamt=0, A=0x1234 -> done in cycle 10, result=0x1234.
5. Reset: STEP=1, SRL of 0xFFFFFFFF with shamt=20; drive reset=0 in cycle 5 -> next cycle busy=0, done=0, result=0, flags=0. No done pulse appears afterwards.
6. Reserved funct=111 with shamt=7 and A=0xA5 -> done in cycle 1, result=0xA5. Also run WIDTH=16 with op=0, alu_sel=100, A=0xFFFF -> result=0, zero=1, overflow=0.
